// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction fetch stage: the FSM state type,
// the sequential PC step and the instruction width, plus a small helper
// that clears the byte-offset bits of an address.
//
// Configuration macro: FETCH_MISALIGN_TRAP_EN adds the FAULT state.

package fetch_pkg;

    localparam logic [31:0] PC_STEP = 32'd4;
    localparam int          INSTR_W = 32;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
        , FAULT
`endif
    } fetch_state_t;

    // Force an address onto a 4-byte instruction boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch
// Fetch stage sitting between the (reset-less) PC register and decode.
// Loads the reset vector into the PC, issues one instruction-memory read per
// instruction, holds the returned word for decode under valid/ready, and
// commits the next PC (sequential +4 or an execute-stage redirect).
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   current_pc                    PC register output
//   pc_update_en, next_pc         PC register load enable / load value (combinational)
//   imem_req, imem_addr           one-cycle read request / address (address combinational)
//   imem_rvalid, imem_rdata       read response
//   redirect_valid, redirect_pc   taken branch/jump pulse and target
//   instr_valid, instr_ready      handshake towards decode
//   instr, instr_pc               fetched word and the address it came from
//   fetch_fault                   misaligned redirect trap flag
//
// Configuration macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect leaves the PC alone, raises fetch_fault
//               and parks the stage in FAULT until reset.
//   undefined : redirect targets are word-aligned by dropping bits [1:0];
//               fetch_fault stays 0.

module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        current_pc,
    output logic               pc_update_en,
    output logic [31:0]        next_pc,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    output logic               fetch_fault
);

    fetch_state_t state;

    // Set when a request is outstanding whose data belongs to a path that a
    // redirect has already abandoned.
    logic discard;

    // A redirect that actually moves the PC this cycle.
    logic redirect_take;

`ifdef FETCH_MISALIGN_TRAP_EN
    // A misaligned redirect that must trap instead of moving the PC.
    logic redirect_trap;
`endif

    // The request is launched from the registered state, so the address is
    // simply whatever the PC register currently holds.
    assign imem_addr = current_pc;

    // PC update control. Nothing moves while reset is held, BOOT loads the
    // reset vector, redirects win over the sequential step, and the +4 step
    // only happens when decode takes the held instruction.
    always_comb begin
        next_pc       = current_pc + PC_STEP;
        pc_update_en  = 1'b0;
        redirect_take = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        redirect_trap = 1'b0;
`endif
        if (!reset) begin
            case (state)
                BOOT: begin
                    pc_update_en = 1'b1;
                    next_pc      = RESET_PC;
                end
                REQ, WAIT, HOLD: begin
                    if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (redirect_pc[1:0] != 2'b00) begin
                            redirect_trap = 1'b1;
                        end else begin
                            redirect_take = 1'b1;
                            pc_update_en  = 1'b1;
                            next_pc       = redirect_pc;
                        end
`else
                        redirect_take = 1'b1;
                        pc_update_en  = 1'b1;
                        next_pc       = word_align(redirect_pc);
`endif
                    end else if (state == HOLD && instr_valid && instr_ready) begin
                        pc_update_en = 1'b1;
                    end
                end
                default: begin
                    pc_update_en = 1'b0;
                end
            endcase
        end
    end

    // Fetch FSM with registered outputs. imem_req is raised on every
    // transition into REQ so that it is high exactly during the REQ cycle,
    // the cycle in which the PC register already shows the new address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            fetch_fault <= 1'b0;
            discard     <= 1'b0;
        end else begin
            imem_req <= 1'b0;
            case (state)
                BOOT: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    state <= WAIT;
                    // The request already went out for the old PC.
                    if (redirect_take) begin
                        discard <= 1'b1;
                    end
                end
                WAIT: begin
                    if (redirect_take) begin
                        // Data arriving alongside the redirect is stale;
                        // without data the response is still owed, so remember
                        // to drop it.
                        if (imem_rvalid) begin
                            discard  <= 1'b0;
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end else begin
                            discard <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (discard) begin
                            discard  <= 1'b0;
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= current_pc;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_take || (instr_valid && instr_ready)) begin
                        instr_valid <= 1'b0;
                        state       <= REQ;
                        imem_req    <= 1'b1;
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                FAULT: begin
                    state <= FAULT;
                end
`endif
                default: begin
                    state <= BOOT;
                end
            endcase
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_trap) begin
                state       <= FAULT;
                fetch_fault <= 1'b1;
                instr_valid <= 1'b0;
                imem_req    <= 1'b0;
                discard     <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch
// Bench for instruction_fetch. Surrounds the fetch stage with a PC register,
// an instruction memory of programmable latency, and a decode-side driver.
// The reference model tracks the architectural fetch address: it starts at
// the reset vector, steps by 4 when decode accepts an instruction and jumps
// to the word-aligned target on a redirect. Every accepted instruction is
// pushed into a queue by the driver and popped/compared by a monitor.
// Honours FETCH_MISALIGN_TRAP_EN for the misaligned redirect scenario.

module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] current_pc = 32'hDEAD_BEEC;
    logic        pc_update_en;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] exp_pc = RESET_PC;
    bit          model_on = 1'b0;
    int          hs_count = 0;
    int          hs_cycles[$];

    int          mem_latency = 1;
    bit          mem_rand = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr_q = 32'h0;

    instruction_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .current_pc     (current_pc),
        .pc_update_en   (pc_update_en),
        .next_pc        (next_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // External PC register: no reset, loads next_pc when enabled.
    always @(posedge clk) begin
        if (pc_update_en) current_pc <= next_pc;
    end

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Instruction memory: a request seen in cycle t answers in cycle t+L.
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        if (reset) begin
            mem_cnt = 0;
        end else begin
            if (mem_cnt > 0) begin
                mem_cnt = mem_cnt - 1;
                if (mem_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(mem_addr_q);
                end
            end
            if (imem_req) begin
                mem_addr_q = imem_addr;
                mem_cnt    = mem_rand ? int'($urandom_range(1, 4)) : mem_latency;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of decode/execute inputs and advance the model.
    task automatic applyStimulus(input logic rd, input logic [31:0] tgt, input logic rdy);
        bit hs;
        @(negedge clk);
        redirect_valid = rd;
        redirect_pc    = tgt;
        instr_ready    = rdy;
        #1;
        hs = (instr_valid === 1'b1) && rdy;
        if (hs) begin
            hs_count++;
            hs_cycles.push_back(cycle);
        end
        if (model_on) begin
            if (hs) exp_q.push_back('{pc: exp_pc, word: mem_word(exp_pc)});
            if (rd) exp_pc = tgt & 32'hFFFF_FFFC;
            else if (hs) exp_pc = exp_pc + 32'd4;
        end
    endtask

    // Bounded wait: what=0 waits for imem_req, what=1 for instr_valid.
    task automatic runUntil(input int what, input logic rdy, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            applyStimulus(1'b0, 32'h0, rdy);
            hit = (what == 0) ? (imem_req === 1'b1) : (instr_valid === 1'b1);
        end
        total++;
        if (!hit) begin
            bad++;
            $display("[TB] FAIL %s: no event within %0d cycles", name, budget);
        end
    endtask

    // Scoreboard monitor: every handshake consumes one expected instruction.
    always begin
        @(negedge clk);
        #2;
        if (model_on && !reset && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL sb_empty: handshake at pc %h with nothing expected", instr_pc);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("sb_instr_pc", instr_pc, mon_e.pc);
                checkOutput("sb_instr", instr, mon_e.word);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          viol;
        int          n;
        bit          saw_valid;
        bit          found;
        logic        rd;
        logic [31:0] tgt;

        // Reset state.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_instr_valid", instr_valid, 0);
        checkOutput("rst_imem_req", imem_req, 0);
        checkOutput("rst_pc_update_en", pc_update_en, 0);
        checkOutput("rst_fetch_fault", fetch_fault, 0);
        checkOutput("rst_instr", instr, 0);
        checkOutput("rst_instr_pc", instr_pc, 0);

        reset  = 1'b0;
        exp_pc = RESET_PC;
        exp_q.delete();
        model_on = 1'b1;
        #1;
        checkOutput("boot_pc_update_en", pc_update_en, 1);
        checkOutput("boot_next_pc", next_pc, RESET_PC);

        // L=1, decode always ready: three instructions, one every 3 cycles.
        mem_latency = 1;
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("req_imem_req", imem_req, 1);
        checkOutput("req_imem_addr", imem_addr, RESET_PC);
        checkOutput("req_pc_update_en", pc_update_en, 0);
        n = hs_count;
        for (int i = 0; i < 30 && hs_count - n < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("stream_count", hs_count - n, 3);
        if (hs_cycles.size() >= 3) begin
            checkOutput("stream_gap1", hs_cycles[hs_cycles.size()-2] - hs_cycles[hs_cycles.size()-3], 3);
            checkOutput("stream_gap2", hs_cycles[hs_cycles.size()-1] - hs_cycles[hs_cycles.size()-2], 3);
        end

        // Decode stalls for 5 cycles in HOLD.
        runUntil(1, 1'b0, 20, "wait_hold");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
            checkOutput("stall_valid", instr_valid, 1);
            checkOutput("stall_instr_pc", instr_pc, exp_pc);
            checkOutput("stall_instr", instr, mem_word(exp_pc));
            checkOutput("stall_imem_req", imem_req, 0);
            checkOutput("stall_pc_update_en", pc_update_en, 0);
        end

        // Redirect to 0x200 while waiting on a slow (L=4) read.
        mem_latency = 4;
        runUntil(0, 1'b1, 20, "req_before_redirect");
        applyStimulus(1'b1, 32'h200, 1'b1);
        checkOutput("wait_redir_pc_update_en", pc_update_en, 1);
        checkOutput("wait_redir_next_pc", next_pc, 32'h200);
        saw_valid = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            if (instr_valid === 1'b1) saw_valid = 1'b1;
            if (imem_req === 1'b1) found = 1'b1;
        end
        checkOutput("wait_redir_dropped", saw_valid, 0);
        checkOutput("wait_redir_refetch", found, 1);
        checkOutput("wait_redir_addr", imem_addr, 32'h200);

        // Redirect to 0x300 in the same cycle as a handshake in HOLD.
        mem_latency = 1;
        runUntil(1, 1'b0, 20, "wait_hold_redirect");
        applyStimulus(1'b1, 32'h300, 1'b1);
        checkOutput("hold_redir_pc_update_en", pc_update_en, 1);
        checkOutput("hold_redir_next_pc", next_pc, 32'h300);
        runUntil(0, 1'b1, 10, "req_after_hold_redirect");
        checkOutput("hold_redir_addr", imem_addr, 32'h300);

        // Randomized traffic: random latency, stalls and redirects.
        mem_rand = 1'b1;
        n = hs_count;
        for (int i = 0; i < 600; i++) begin
            rd  = ($urandom_range(0, 9) == 0);
            tgt = $urandom & 32'h0000_FFFF;
`ifdef FETCH_MISALIGN_TRAP_EN
            tgt = tgt & 32'hFFFF_FFFC;
`endif
            applyStimulus(rd, tgt, ($urandom_range(0, 3) != 0));
        end
        mem_rand = 1'b0;
        checkOutput("random_progress", (hs_count - n) >= 40, 1);

        // Misaligned redirect to 0x302 while waiting.
        runUntil(0, 1'b1, 20, "req_before_misaligned");
`ifdef FETCH_MISALIGN_TRAP_EN
        model_on = 1'b0;
        applyStimulus(1'b1, 32'h302, 1'b1);
        checkOutput("trap_pc_update_en", pc_update_en, 0);
        viol = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            if (i == 0) checkOutput("trap_fetch_fault", fetch_fault, 1);
            if (imem_req !== 1'b0 || pc_update_en !== 1'b0) viol++;
        end
        checkOutput("trap_quiet", viol, 0);
`else
        applyStimulus(1'b1, 32'h302, 1'b1);
        checkOutput("misalign_pc_update_en", pc_update_en, 1);
        checkOutput("misalign_next_pc", next_pc, 32'h300);
        runUntil(0, 1'b1, 10, "req_after_misaligned");
        checkOutput("misalign_addr", imem_addr, 32'h300);
        runUntil(1, 1'b1, 10, "valid_after_misaligned");
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("misalign_fetch_fault", fetch_fault, 0);
`endif

        @(negedge clk);
        #3;
        checkOutput("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
